light_blinker_multi: RTL and testbench

Parametrised multi-channel lamp controller, the successor to the single-lamp enable-gated blinker. Each of `CHANNELS` outputs independently runs as off, steady-on, continuous blink or a counted burst, timed by one shared prescaler. Sits between the board-level control logic (per-channel enable and mode) and the LED/lamp pins.

---
 rtl/light_blinker_multi.sv | 145 ++++++++++++++
 tb/tb_light_blinker_multi.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/light_blinker_multi.sv
// Multi-channel lamp controller: per-channel off / steady / blink / counted burst,
// all channels timed from one free-running shared prescaler.
module light_blinker_multi #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PRESCALE    = 50_000,
    parameter int unsigned ON_TICKS    = 500,
    parameter int unsigned OFF_TICKS   = 500,
    parameter int unsigned BURST_COUNT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CHANNELS-1:0]   enable_i,
    input  logic [2*CHANNELS-1:0] mode_i,
    output logic [CHANNELS-1:0]   light_o,
    output logic [CHANNELS-1:0]   done_o
);

    localparam int unsigned PHASE_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned BURST_W   = $clog2(BURST_COUNT + 1);
    localparam int unsigned PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_STEADY = 2'd1;
    localparam logic [1:0] M_BLINK  = 2'd2;

    // Shared prescaler; free-runs and is never disturbed by channel activity.
    logic [PRE_W-1:0] pre_q;
    logic             tick_c;

    assign tick_c = (pre_q == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else if (tick_c) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [1:0]         mode_c;
        logic               start_c;
        logic [1:0]         state_q;
        logic [1:0]         state_d;
        logic [PHASE_W-1:0] phase_q;
        logic [PHASE_W-1:0] phase_d;
        logic [BURST_W-1:0] burst_q;
        logic [BURST_W-1:0] burst_d;
        logic [BURST_W-1:0] burst_inc_c;
        logic               done_d;
        logic               prev_en_q;
        logic [1:0]         prev_mode_q;
        logic               light_q;
        logic               done_q;

        assign mode_c      = mode_i[2*n +: 2];
        assign start_c     = enable_i[n] & (~prev_en_q | (mode_c != prev_mode_q));
        assign burst_inc_c = burst_q + BURST_W'(1);

        // Next-state: disable dominates, then (re)start, then phase sequencing.
        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            burst_d = burst_q;
            done_d  = 1'b0;
            if (!enable_i[n]) begin
                state_d = S_IDLE;
                phase_d = '0;
                burst_d = '0;
            end else if (start_c) begin
                phase_d = '0;
                burst_d = '0;
                state_d = (mode_c == M_OFF) ? S_IDLE : S_ON;
            end else begin
                case (state_q)
                    S_ON: begin
                        if (mode_c != M_STEADY && tick_c) begin
                            if (phase_q == PHASE_W'(ON_TICKS - 1)) begin
                                state_d = S_OFF;
                                phase_d = '0;
                            end else begin
                                phase_d = phase_q + PHASE_W'(1);
                            end
                        end
                    end
                    S_OFF: begin
                        if (tick_c) begin
                            if (phase_q == PHASE_W'(OFF_TICKS - 1)) begin
                                phase_d = '0;
                                if (mode_c == M_BLINK) begin
                                    state_d = S_ON;
                                end else begin
                                    burst_d = burst_inc_c;
                                    if (burst_inc_c == BURST_W'(BURST_COUNT)) begin
                                        state_d = S_DONE;
                                        done_d  = 1'b1;
                                    end else begin
                                        state_d = S_ON;
                                    end
                                end
                            end else begin
                                phase_d = phase_q + PHASE_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q     <= S_IDLE;
                phase_q     <= '0;
                burst_q     <= '0;
                prev_en_q   <= 1'b0;
                prev_mode_q <= 2'b00;
                light_q     <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                phase_q     <= phase_d;
                burst_q     <= burst_d;
                prev_en_q   <= enable_i[n];
                prev_mode_q <= mode_c;
                light_q     <= (state_d == S_ON);
                done_q      <= done_d;
            end
        end

        assign light_o[n] = light_q;
        assign done_o[n]  = done_q;
    end

endmodule

// File: tb/tb_light_blinker_multi.sv
// Randomised + directed bench for light_blinker_multi; expectations come from a
// per-channel "cycles since start" model of the blink/burst waveform.
module tb_light_blinker_multi;

    localparam int unsigned CH    = 2;
    localparam int unsigned ON_T  = 3;
    localparam int unsigned OFF_T = 2;
    localparam int unsigned BURST = 2;
    localparam int          PER   = ON_T + OFF_T;
    localparam int          BLEN  = BURST * PER;

    logic          clk;
    logic          rst;
    logic [CH-1:0] enable;
    logic [2*CH-1:0] mode;
    logic [CH-1:0] light;
    logic [CH-1:0] done;

    int checks = 0;
    int errors = 0;

    // Model state: previous inputs, cycles since start (-1 when inactive), expectations.
    logic       m_prev_en [CH];
    logic [1:0] m_prev_md [CH];
    int         m_k       [CH];
    logic [CH-1:0] exp_light;
    logic [CH-1:0] exp_done;

    light_blinker_multi #(
        .CHANNELS(CH), .PRESCALE(1), .ON_TICKS(ON_T),
        .OFF_TICKS(OFF_T), .BURST_COUNT(BURST)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
        .light_o(light), .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_prev_en[c] = 1'b0;
            m_prev_md[c] = 2'b00;
            m_k[c]       = -1;
        end
        exp_light = '0;
        exp_done  = '0;
    endtask

    // Predicts outputs after the coming edge from the waveform position k.
    task automatic model_step(input logic [CH-1:0] en, input logic [2*CH-1:0] md);
        for (int c = 0; c < CH; c++) begin
            logic [1:0] m;
            m = md[2*c +: 2];
            exp_light[c] = 1'b0;
            exp_done[c]  = 1'b0;
            if (!en[c]) begin
                m_k[c] = -1;
            end else begin
                if (!m_prev_en[c] || m != m_prev_md[c]) m_k[c] = 0;
                else m_k[c] = m_k[c] + 1;
                case (m)
                    2'd1: exp_light[c] = 1'b1;
                    2'd2: exp_light[c] = ((m_k[c] % PER) < ON_T);
                    2'd3: begin
                        exp_light[c] = (m_k[c] < BLEN) && ((m_k[c] % PER) < ON_T);
                        exp_done[c]  = (m_k[c] == BLEN);
                    end
                    default: exp_light[c] = 1'b0;
                endcase
            end
            m_prev_en[c] = en[c];
            m_prev_md[c] = m;
        end
    endtask

    // Drive inputs just after a falling edge, then compare after the next rising edge.
    task automatic step(input logic [CH-1:0] en, input logic [2*CH-1:0] md);
        enable = en;
        mode   = md;
        model_step(en, md);
        @(negedge clk);
        check("light", light, exp_light);
        check("done", done, exp_done);
    endtask

    initial begin
        logic [9:0] pat;
        logic [CH-1:0] en_r;
        logic [2*CH-1:0] md_r;
        pat = 10'b11100_11100;

        rst = 1'b1;
        enable = 2'b11;
        mode = 4'b1010;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_light", light, 2'b00);
            check("reset_done", done, 2'b00);
        end
        rst = 1'b0;
        enable = 2'b00;
        for (int i = 0; i < 2; i++) step(2'b00, 4'b0000);

        // Blink on ch0.
        for (int i = 0; i < 10; i++) begin
            step(2'b01, 4'b0010);
            check("blink_lit", {1'b0, light[0]}, {1'b0, pat[9-i]});
            check("blink_done", done, 2'b00);
        end
        step(2'b00, 4'b0010);

        // Steady on ch1.
        for (int i = 0; i < 4; i++) begin
            step(2'b10, 4'b0100);
            check("steady_lit", light, 2'b10);
        end
        step(2'b00, 4'b0100);
        check("steady_off", light, 2'b00);

        // Burst on ch0, hold, then re-enable.
        for (int i = 0; i < 10; i++) begin
            step(2'b01, 4'b0011);
            check("burst_lit", {1'b0, light[0]}, {1'b0, pat[9-i]});
        end
        step(2'b01, 4'b0011);
        check("burst_done", done, 2'b01);
        check("burst_done_dark", light, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 4'b0011);
            check("burst_hold", {light, done}, 4'b0000);
        end
        step(2'b00, 4'b0011);
        for (int i = 0; i < 5; i++) begin
            step(2'b01, 4'b0011);
            check("burst_again", {1'b0, light[0]}, {1'b0, pat[9-i]});
        end
        step(2'b00, 4'b0011);

        // Disable at the burst-completing edge: no done pulse.
        for (int i = 0; i < 10; i++) step(2'b01, 4'b0011);
        step(2'b00, 4'b0011);
        check("disable_wins", done, 2'b00);

        // Restart ch0 mid-OFF while ch1 blinks on.
        for (int i = 0; i < 4; i++) step(2'b11, 4'b1010);
        check("pre_restart", {1'b0, light[0]}, 2'b00);
        step(2'b11, 4'b1011);
        check("restart_on", {1'b0, light[0]}, 2'b01);
        check("ch1_untouched", {1'b0, light[1]}, 2'b00);
        for (int i = 0; i < 6; i++) step(2'b11, 4'b1011);
        step(2'b00, 4'b0000);

        // Async reset between edges while both lamps lit.
        step(2'b11, 4'b0101);
        check("both_lit", light, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("async_light", light, 2'b00);
        check("async_done", done, 2'b00);
        #1 rst = 1'b0;
        model_reset();
        step(2'b11, 4'b0101);
        check("post_reset_lit", light, 2'b11);

        // Random traffic.
        en_r = 2'b11;
        md_r = 4'b1110;
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 15) == 0) en_r[c] = ~en_r[c];
                if ($urandom_range(0, 23) == 0) md_r[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            step(en_r, md_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
